// File: rtl/ctrl_decode_pipe_pkg.sv
// Shared types and encodings for the RV32I main control decoder (package ctrl_pkg).
// Opcode constants, ImmSrc / ResultSrc / ALUOp encodings and the ctrl_t bundle.
`timescale 1ns/1ps
package ctrl_pkg;

  // Base opcodes (instr[6:0])
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Immediate format select
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // Writeback result select
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;
  localparam logic [1:0] RES_IMM = 2'b11;

  // ALU operation class
  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       alu_src;
    logic [2:0] imm_src;
    logic [1:0] alu_op;
    logic       branch;
    logic       jump;
    logic       jump_reg;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/ctrl_decode_pipe_if.sv
// Decode-pipe handshake bundle: instruction side in, control bundle side out.
// master = the surrounding core (drives instructions, accepts bundles), slave = the decoder.
`timescale 1ns/1ps
interface ctrl_decode_pipe_if
  import ctrl_pkg::*;
#(
  parameter int PC_W = 32
) ();

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr;
  logic [PC_W-1:0] pc;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  ctrl_t           out_ctrl;
  logic [2:0]      out_funct3;
  logic [PC_W-1:0] out_pc;

  modport master (
    output in_valid, instr, pc, flush, out_ready,
    input  in_ready, out_valid, out_ctrl, out_funct3, out_pc
  );

  modport slave (
    input  in_valid, instr, pc, flush, out_ready,
    output in_ready, out_valid, out_ctrl, out_funct3, out_pc
  );

endinterface

// File: rtl/ctrl_decode_comb.sv
// Purely combinational opcode -> ctrl_t decoder.
// Optional feature macro: CTRL_DECODE_UTYPE_EN adds LUI/AUIPC; without it they decode as Illegal.
`timescale 1ns/1ps
module ctrl_decode_comb
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output ctrl_t      ctrl
);

  // Every field defaults to 0; each opcode only raises what it needs
  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_R: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      OP_I: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.imm_src   = IMM_I;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      OP_LOAD: begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.imm_src    = IMM_I;
        ctrl.result_src = RES_MEM;
      end
      OP_STORE: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.imm_src   = IMM_S;
      end
      OP_BRANCH: begin
        ctrl.branch  = 1'b1;
        ctrl.imm_src = IMM_B;
        ctrl.alu_op  = ALUOP_BRANCH;
      end
      OP_JAL: begin
        ctrl.jump       = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.imm_src    = IMM_J;
        ctrl.result_src = RES_PC4;
      end
      OP_JALR: begin
        ctrl.jump       = 1'b1;
        ctrl.jump_reg   = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.imm_src    = IMM_I;
        ctrl.result_src = RES_PC4;
      end
`ifdef CTRL_DECODE_UTYPE_EN
      OP_LUI: begin
        ctrl.reg_write  = 1'b1;
        ctrl.imm_src    = IMM_U;
        ctrl.result_src = RES_IMM;
      end
      // Execute picks the PC operand itself from out_pc
      OP_AUIPC: begin
        ctrl.reg_write  = 1'b1;
        ctrl.imm_src    = IMM_U;
        ctrl.alu_src    = 1'b1;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.result_src = RES_ALU;
      end
`endif
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_decode_pipe.sv
// Pipelined main control decoder: decode in front of stage 0, then DEPTH
// valid/ready register stages with collapsing bubbles, flush, and a saturating
// illegal-instruction counter. Optional macro CTRL_DECODE_UTYPE_EN enables LUI/AUIPC.
`timescale 1ns/1ps
module ctrl_decode_pipe
  import ctrl_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PC_W  = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  ctrl_decode_pipe_if.slave bus,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  ctrl_t dec_ctrl;

  logic [DEPTH-1:0] valid_reg;
  ctrl_t            ctrl_reg   [DEPTH];
  logic [2:0]       funct3_reg [DEPTH];
  logic [PC_W-1:0]  pc_reg     [DEPTH];

  logic [DEPTH-1:0] src_valid;
  ctrl_t            src_ctrl   [DEPTH];
  logic [2:0]       src_funct3 [DEPTH];
  logic [PC_W-1:0]  src_pc     [DEPTH];

  logic [DEPTH-1:0] load;
  logic             accept;
  logic             unused_instr_bits;

  ctrl_decode_comb u_decode (
    .opcode (bus.instr[6:0]),
    .ctrl   (dec_ctrl)
  );

  // Only opcode and funct3 matter here; the rest of the word belongs to later stages
  assign unused_instr_bits = ^{bus.instr[31:15], bus.instr[11:7]};

  // A stage can load when it is empty or its occupant moves on; walk from the output back
  always_comb begin : ready_chain
    logic down_rdy;
    down_rdy = bus.out_ready;
    load     = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      load[k]  = !valid_reg[k] || down_rdy;
      down_rdy = load[k];
    end
  end

  assign bus.in_ready = !bus.flush && load[0];
  assign accept       = bus.in_valid && bus.in_ready;

  // Stage 0 is fed by the decoder, every later stage by its predecessor
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_src
    if (gi == 0) begin : g_head
      assign src_valid[gi]  = accept;
      assign src_ctrl[gi]   = dec_ctrl;
      assign src_funct3[gi] = bus.instr[14:12];
      assign src_pc[gi]     = bus.pc;
    end else begin : g_body
      assign src_valid[gi]  = valid_reg[gi-1];
      assign src_ctrl[gi]   = ctrl_reg[gi-1];
      assign src_funct3[gi] = funct3_reg[gi-1];
      assign src_pc[gi]     = pc_reg[gi-1];
    end
  end

  // Stage registers: flush kills validity, data only moves with a real occupant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        ctrl_reg[k]   <= '0;
        funct3_reg[k] <= '0;
        pc_reg[k]     <= '0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (bus.flush) begin
          valid_reg[k] <= 1'b0;
        end else if (load[k]) begin
          valid_reg[k] <= src_valid[k];
        end
        if (load[k] && src_valid[k]) begin
          ctrl_reg[k]   <= src_ctrl[k];
          funct3_reg[k] <= src_funct3[k];
          pc_reg[k]     <= src_pc[k];
        end
      end
    end
  end

  // Count accepted illegal instructions, sticking at all-ones; flush leaves it alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_cnt <= '0;
    end else if (accept && dec_ctrl.illegal && (illegal_cnt != CNT_MAX)) begin
      illegal_cnt <= illegal_cnt + CNT_W'(1);
    end
  end

  assign bus.out_valid  = valid_reg[DEPTH-1];
  assign bus.out_ctrl   = ctrl_reg[DEPTH-1];
  assign bus.out_funct3 = funct3_reg[DEPTH-1];
  assign bus.out_pc     = pc_reg[DEPTH-1];

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Self-checking bench for ctrl_decode_pipe: opcode table, directed handshake
// sequences and a randomized run against a queue-based reference model.
`timescale 1ns/1ps
module tb_ctrl_decode_pipe;
  import ctrl_pkg::*;

  localparam int DEPTH   = 2;
  localparam int PC_W    = 32;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = 3;
  localparam int NTBL    = 12;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [CNT_W-1:0] illegal_cnt;

  ctrl_decode_pipe_if #(.PC_W(PC_W)) bus ();

  ctrl_decode_pipe #(.DEPTH(DEPTH), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .illegal_cnt (illegal_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]     instr;
    logic [PC_W-1:0] pc;
    int              acc;
  } item_t;

  typedef struct {
    logic [31:0] instr;
    ctrl_t       exp;
  } vec_t;

  int    checks  = 0;
  int    errors  = 0;
  int    cyc     = 0;
  int    exp_cnt = 0;
  item_t q[$];
  vec_t  tbl[NTBL];

  function automatic ctrl_t mk(bit rw, bit [1:0] rs, bit mw, bit as, bit [2:0] is,
                               bit [1:0] ao, bit br, bit j, bit jr, bit il);
    ctrl_t c;
    c.reg_write = rw; c.result_src = rs; c.mem_write = mw; c.alu_src = as;
    c.imm_src = is; c.alu_op = ao; c.branch = br; c.jump = j; c.jump_reg = jr;
    c.illegal = il;
    return c;
  endfunction

  // Reference decode: look the opcode up in the expectation table; unknown -> illegal
  function automatic ctrl_t ref_ctrl(logic [31:0] instr);
    for (int i = 0; i < NTBL; i++)
      if (tbl[i].instr[6:0] == instr[6:0]) return tbl[i].exp;
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic drive(bit v, logic [31:0] ins, bit ordy, bit fl);
    bus.in_valid  = v;
    bus.instr     = ins;
    bus.pc        = $urandom;
    bus.out_ready = ordy;
    bus.flush     = fl;
  endtask

  // One clock: compare DUT against the model, take the edge, advance the model
  task automatic tick();
    bit    exp_rdy, exp_ov, ill;
    ctrl_t rc;
    #1;
    exp_rdy = !bus.flush && ((q.size() < DEPTH) || bus.out_ready);
    exp_ov  = (q.size() > 0) && ((cyc - q[0].acc) >= DEPTH - 1);
    chk("in_ready", bus.in_ready, exp_rdy);
    chk("out_valid", bus.out_valid, exp_ov);
    chk("illegal_cnt", illegal_cnt, exp_cnt);
    if (exp_ov && bus.out_valid) begin
      rc = ref_ctrl(q[0].instr);
      chk("out_ctrl", bus.out_ctrl, rc);
      chk("out_funct3", bus.out_funct3, q[0].instr[14:12]);
      chk("out_pc", bus.out_pc, q[0].pc);
    end
    @(posedge clk);
    cyc++;
    if (exp_ov && bus.out_ready) begin
      $display("XFER cyc=%0d instr=%08h pc=%08h ctrl=%04h", cyc, q[0].instr, q[0].pc, bus.out_ctrl);
      void'(q.pop_front());
    end
    if (bus.flush) begin
      q.delete();
    end else if (bus.in_valid && exp_rdy) begin
      q.push_back('{bus.instr, bus.pc, cyc});
      rc  = ref_ctrl(bus.instr);
      ill = rc.illegal;
      if (ill && exp_cnt < CNT_MAX) exp_cnt++;
    end
    @(negedge clk);
  endtask

  task automatic wait_out(output bit found);
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (bus.out_valid) begin
        found = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 32'h0, 1, 0);
    q.delete();
    exp_cnt = 0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_cnt", illegal_cnt, 0);
    chk("rst_ctrl", bus.out_ctrl, 0);
    chk("rst_funct3", bus.out_funct3, 0);
    chk("rst_pc", bus.out_pc, 0);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          found;
    int          acc, n;
    bit          rdy;
    logic [31:0] s[3];
    logic [31:0] b[3];
    logic [31:0] r;
    logic [6:0]  ops[10];

    tbl[0]  = '{32'h002081B3, mk(1, 2'b00, 0, 0, 3'b000, 2'b10, 0, 0, 0, 0)};  // R
    tbl[1]  = '{32'h00A00093, mk(1, 2'b00, 0, 1, 3'b000, 2'b10, 0, 0, 0, 0)};  // I-ALU
    tbl[2]  = '{32'h0000A103, mk(1, 2'b01, 0, 1, 3'b000, 2'b00, 0, 0, 0, 0)};  // load
    tbl[3]  = '{32'h00112223, mk(0, 2'b00, 1, 1, 3'b001, 2'b00, 0, 0, 0, 0)};  // store
    tbl[4]  = '{32'h00208463, mk(0, 2'b00, 0, 0, 3'b010, 2'b01, 1, 0, 0, 0)};  // branch
    tbl[5]  = '{32'h008000EF, mk(1, 2'b10, 0, 0, 3'b011, 2'b00, 0, 1, 0, 0)};  // JAL
    tbl[6]  = '{32'h000080E7, mk(1, 2'b10, 0, 1, 3'b000, 2'b00, 0, 1, 1, 0)};  // JALR
`ifdef CTRL_DECODE_UTYPE_EN
    tbl[7]  = '{32'h123450B7, mk(1, 2'b11, 0, 0, 3'b100, 2'b00, 0, 0, 0, 0)};  // LUI
    tbl[8]  = '{32'h00000097, mk(1, 2'b00, 0, 1, 3'b100, 2'b00, 0, 0, 0, 0)};  // AUIPC
`else
    tbl[7]  = '{32'h123450B7, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1)};
    tbl[8]  = '{32'h00000097, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1)};
`endif
    tbl[9]  = '{32'hFFFFFFFF, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1)};
    tbl[10] = '{32'h00000000, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1)};
    tbl[11] = '{32'h0000000F, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1)};

    s[0] = 32'h00A00093; s[1] = 32'h0000A103; s[2] = 32'h00112223;
    b[0] = 32'h002081B3; b[1] = 32'h00A00093; b[2] = 32'h00208463;
    for (int i = 0; i < 10; i++) ops[i] = tbl[i + 2].instr[6:0];
    ops[0] = 7'b0110011;

    do_reset();

    // Illegal word: counter 0 -> 1, write enables low, then saturation at 3
    drive(1, 32'hFFFFFFFF, 1, 0);
    tick();
    drive(0, 32'h0, 1, 0);
    #1;
    chk("ill_cnt_first", illegal_cnt, 1);
    wait_out(found);
    chk("ill_found", found, 1);
    chk("ill_flag", bus.out_ctrl.illegal, 1);
    chk("ill_regwrite", bus.out_ctrl.reg_write, 0);
    chk("ill_memwrite", bus.out_ctrl.mem_write, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1, 32'hFFFFFFFF, 1, 0);
      tick();
    end
    drive(0, 32'h0, 1, 0);
    repeat (3) tick();
    chk("ill_cnt_sat", illegal_cnt, 3);

    do_reset();

    // Opcode table: each entry sent alone, checked on arrival with its latency
    for (int i = 0; i < NTBL; i++) begin
      drive(1, tbl[i].instr, 1, 0);
      tick();
      acc = cyc;
      drive(0, 32'h0, 1, 0);
      wait_out(found);
      chk("tbl_found", found, 1);
      if (found) begin
        chk($sformatf("tbl_ctrl_%08h", tbl[i].instr), bus.out_ctrl, tbl[i].exp);
        chk("tbl_latency", cyc - acc, DEPTH - 1);
      end
      tick();
    end

    // Back-to-back stream with out_ready high
    for (int i = 0; i < 3; i++) begin
      drive(1, s[i], 1, 0);
      tick();
      #1;
      chk("stream_out_valid", bus.out_valid, (i + 1) >= DEPTH);
    end
    drive(0, 32'h0, 1, 0);
    repeat (4) tick();

    // Backpressure: only DEPTH of three get in, head holds, then drains in order
    n = 0;
    for (int c = 0; c < 3; c++) begin
      drive(1, b[(n < 2) ? n : 2], 0, 0);
      #1;
      rdy = bus.in_ready;
      if (c == 2) chk("bp_full_in_ready", rdy, 0);
      tick();
      if (rdy) n++;
    end
    chk("bp_accepted", n, 2);
    drive(0, 32'h0, 0, 0);
    repeat (2) tick();
    #1;
    chk("bp_hold_valid", bus.out_valid, 1);
    chk("bp_hold_ctrl", bus.out_ctrl, ref_ctrl(b[0]));
    drive(0, 32'h0, 1, 0);
    repeat (4) tick();

    do_reset();

    // Flush on a full pipe with in_valid high: nothing taken, counter untouched
    drive(1, 32'h00A00093, 0, 0); tick();
    drive(1, 32'h0000A103, 0, 0); tick();
    drive(1, 32'hFFFFFFFF, 0, 1);
    #1;
    chk("flush_in_ready", bus.in_ready, 0);
    tick();
    drive(0, 32'h0, 0, 0);
    #1;
    chk("flush_out_valid", bus.out_valid, 0);
    chk("flush_cnt", illegal_cnt, 0);
    tick();

    // Flush together with out_ready: head transfers, rest dropped
    drive(1, 32'h00112223, 1, 0); tick();
    drive(1, 32'h002081B3, 1, 0); tick();
    drive(0, 32'h0, 1, 1); tick();
    drive(0, 32'h0, 1, 0);
    #1;
    chk("flush2_out_valid", bus.out_valid, 0);
    tick();

    // Asynchronous reset mid-stream
    drive(1, 32'hFFFFFFFF, 1, 0); tick();
    drive(1, 32'h00A00093, 1, 0); tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", bus.out_valid, 0);
    chk("rst_mid_cnt", illegal_cnt, 0);
    q.delete();
    exp_cnt = 0;
    drive(0, 32'h0, 1, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_mid_in_ready", bus.in_ready, 1);
    tick();

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      r = $urandom;
      drive($urandom_range(0, 3) != 0,
            {r[31:7], ops[$urandom_range(0, 9)]},
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 19) == 0);
      tick();
    end
    drive(0, 32'h0, 1, 0);
    repeat (DEPTH + 2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ctrl_decode_pipe.md
# ctrl_decode_pipe

Pipelined, parametrised main control decoder for the RV32I core. It takes a 32-bit instruction word with PC sideband, decodes the full base control set (R/I/load/store/branch/JAL/JALR, optionally LUI/AUIPC), and carries the control bundle through DEPTH valid/ready register stages to execute. It also supports flush on redirect, flags illegal opcodes with write enables suppressed, and keeps a saturating illegal-instruction counter.

## Interface
- DEPTH, 2, number of register stages between decode and output (1..4)
- PC_W, 32, width of the PC sideband
- CNT_W, 8, width of the illegal-instruction counter
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  instruction word valid
- in_ready  out  1  block can accept this cycle
- instr  in  32  instruction word (opcode = instr[6:0], funct3 = instr[14:12])
- pc  in  PC_W  PC of instr
- flush  in  1  discard every instruction in flight
- out_valid  out  1  output bundle valid
- out_ready  in  1  execute accepts bundle
- out_ctrl  out  ctrl_t  RegWrite, ResultSrc[1:0], MemWrite, ALUSrc, ImmSrc[2:0], ALUOp[1:0], Branch, Jump, JumpReg, Illegal
- out_funct3  out  3  funct3 passthrough
- out_pc  out  PC_W  PC passthrough
- illegal_cnt  out  CNT_W  saturating count of accepted illegal instructions

## Operation
- Opcode 0110011 (R): RegWrite=1, ALUOp=10, ALUSrc=0, ResultSrc=00.
- Opcode 0010011 (I-ALU): RegWrite=1, ALUSrc=1, ImmSrc=000, ALUOp=10.
- Opcode 0000011 (load): RegWrite=1, ALUSrc=1, ImmSrc=000, ResultSrc=01, ALUOp=00.
- Opcode 0100011 (store): MemWrite=1, ALUSrc=1, ImmSrc=001.
- Opcode 1100011 (branch): Branch=1, ImmSrc=010, ALUOp=01.
- Opcode 1101111 (JAL): Jump=1, RegWrite=1, ImmSrc=011, ResultSrc=10.
- Opcode 1100111 (JALR): Jump=1, JumpReg=1, RegWrite=1, ALUSrc=1, ImmSrc=000, ResultSrc=10.
- Any other opcode: Illegal=1, all other fields 0. RegWrite, MemWrite, Branch and Jump must be 0.
- Unlisted fields are 0.
- Pipeline: stage k holds a valid bit plus the bundle. A stage loads when it is empty or when its contents advance this cycle. Bubbles collapse.
- in_ready = !flush && (stage0 empty || stage0 advancing).
- Accept = in_valid && in_ready. The counter increments by 1 on acceptance of an illegal instruction and holds at 2^CNT_W-1.
- flush: all valid bits clear on the next edge. No acceptance in a flush cycle. Output bundle data is don't-care while out_valid=0.
- Simultaneous flush and out_ready: the transfer on the output that cycle completes, then the pipe is empty.
- Reset: all valid bits 0, out_valid=0, in_ready=1 after reset, illegal_cnt=0, out_ctrl/out_funct3/out_pc=0. Reset mid-operation drops everything in flight without producing output.
- Flush does not clear illegal_cnt.

## Timing
- Latency: an instruction accepted at edge N appears with out_valid=1 after edge N+DEPTH-1, provided out_ready stays high.
- Throughput: 1 instruction/cycle with out_ready held high; no bubbles inserted.
- Backpressure: with out_ready=0, the pipe fills after DEPTH accepts, then in_ready=0 in the same cycle combinationally.
- out_* are registered and stable while out_valid && !out_ready.
- in_ready depends combinationally on out_ready and flush only.

## Configuration
- CTRL_DECODE_UTYPE_EN defined:
  - 0110111 (LUI): RegWrite=1, ImmSrc=100, ResultSrc=11.
  - 0010111 (AUIPC): RegWrite=1, ImmSrc=100, ALUSrc=1, ALUOp=00, ResultSrc=00, with the PC-operand select driven by execute from out_pc.
- Not defined: both opcodes decode as Illegal and increment the counter.

## Structure
- Shared package ctrl_pkg holds:
  - ctrl_t packed struct
  - opcode localparams (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC)
  - ImmSrc and ResultSrc encodings
- One sub-module, ctrl_decode_comb: purely combinational opcode to ctrl_t. The top instantiates it before stage 0 and generates DEPTH stages.

## Test plan
- DEPTH=2, out_ready=1, stream 0x00A00093, 0x0000A103, 0x00112223 -> out_valid from cycle 2. Bundles are I (RegWrite=1, ALUSrc=1), load (ResultSrc=01), store (MemWrite=1, ImmSrc=001), in order.
- Hold out_ready=0 and feed 3 instructions -> 2 accepted, in_ready=0, out_* stable. Release out_ready -> both drain in order, one per cycle.
- Instruction 0xFFFFFFFF accepted -> Illegal=1, RegWrite=0, MemWrite=0. illegal_cnt goes 0->1. With CNT_W=2, 5 illegals -> count saturates at 3.
- Pipe full, then flush with in_valid=1 -> nothing accepted that cycle, out_valid=0 the next cycle, illegal_cnt unchanged.
- Assert rst_n low mid-stream between clock edges -> out_valid=0 and illegal_cnt=0 immediately. After release, in_ready=1.
- 0x123450B7 (LUI) -> with CTRL_DECODE_UTYPE_EN, RegWrite=1, ImmSrc=100, ResultSrc=11. Without it, Illegal=1.
